// File: rtl/soc_ins_inject_fifo.sv
// Instruction-injection port: Avalon-MM slave writes are buffered in a DEPTH-entry
// FIFO and streamed to the pipeline over a valid/ready handshake.
module soc_ins_inject_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] inj_data,
    output logic              inj_valid,
    input  logic              inj_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_enable;
    logic              r_irq_en;
    logic              r_overflow;
    logic              r_irq;

    logic              w_wr;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_ovf_clr;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W-1:0] w_head;
    logic [31:0]       w_head_ext;
    logic [31:0]       w_status;
    logic [31:0]       w_control;
    logic [31:0]       w_readdata;

    assign w_wr       = chipselect && !write_n;
    assign w_push_req = w_wr && (address == 2'd0);
    assign w_ctrl_wr  = w_wr && (address == 2'd2);
    assign w_flush    = w_ctrl_wr && writedata[2];
    assign w_ovf_clr  = w_ctrl_wr && writedata[3];
    assign w_empty    = (r_count == {CNT_W{1'b0}});
    assign w_full     = (r_count == CNT_W'(DEPTH));
    // Full is judged on pre-edge state, so a same-cycle pop never admits a push.
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = r_enable && !w_empty && inj_ready && !w_flush;
    assign w_head     = w_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];

    assign inj_data   = w_head;
    assign inj_valid  = r_enable && !w_empty;
    assign irq        = r_irq;
    assign readdata   = w_readdata;

    // Storage array: deliberately not reset, masked on read when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    // Pointers and occupancy; flush has priority over a same-cycle pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (w_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control bits, sticky overflow flag and registered empty interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= writedata[0];
                r_irq_en <= writedata[1];
            end
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_irq <= r_irq_en && w_empty;
        end
    end

    // Register read mux: zero wait states, reflects pre-edge state.
    always_comb begin
        w_head_ext             = 32'd0;
        w_head_ext[DATA_W-1:0] = w_head;
        w_status               = 32'd0;
        w_status[CNT_W-1:0]    = r_count;
        w_status[16]           = w_empty;
        w_status[17]           = w_full;
        w_status[18]           = r_overflow;
        w_control              = 32'd0;
        w_control[0]           = r_enable;
        w_control[1]           = r_irq_en;
        case (address)
            2'd0:    w_readdata = w_head_ext;
            2'd1:    w_readdata = w_status;
            2'd2:    w_readdata = w_control;
            default: w_readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_soc_ins_inject_fifo.sv
// Scoreboard bench for soc_ins_inject_fifo: accepted pushes are queued as expected
// words; a negedge monitor checks every completed handshake against the queue.
module tb_soc_ins_inject_fifo;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] inj_data;
    logic        inj_valid;
    logic        inj_ready;
    logic        irq;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];

    soc_ins_inject_fifo #(.DATA_W(32), .DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .inj_data   (inj_data),
        .inj_valid  (inj_valid),
        .inj_ready  (inj_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic push(input logic [31:0] d, input bit accepted);
        if (accepted) exp_q.push_back(d);
        wr(2'd0, d);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        chk(readdata, exp, name);
    endtask

    // Monitor: every handshake presented before an edge must match the queue head.
    always @(negedge clk) begin
        if (reset_n && inj_valid && inj_ready) begin
            if (exp_q.size() == 0) begin
                chk(inj_data, 32'hxxxx_xxxx, "unexpected_pop");
            end else begin
                chk(inj_data, exp_q.pop_front(), "pop_data");
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        inj_ready  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        rd_chk(2'd1, 32'h0001_0000, "reset_status");
        rd_chk(2'd0, 32'h0000_0000, "reset_data");
        rd_chk(2'd2, 32'h0000_0000, "reset_control");
        chk({31'd0, inj_valid}, 32'd0, "reset_inj_valid");
        chk({31'd0, irq}, 32'd0, "reset_irq");
        chk(inj_data, 32'd0, "reset_inj_data");

        // Two words in order, one-cycle push-to-valid latency
        inj_ready = 1'b1;
        wr(2'd2, 32'h1);
        push(32'h0000_0013, 1'b1);
        chk({31'd0, inj_valid}, 32'd1, "latency_valid");
        chk(inj_data, 32'h0000_0013, "latency_head");
        push(32'h0010_0093, 1'b1);
        repeat (3) tick();
        rd_chk(2'd1, 32'h0001_0000, "two_words_drained");

        // Overflow with enable cleared, then drain exactly 8
        inj_ready = 1'b0;
        wr(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) push(32'h100 + i, i < 8);
        rd_chk(2'd1, 32'h0006_0008, "full_overflow_status");
        chk({31'd0, inj_valid}, 32'd0, "disabled_no_valid");
        chk(inj_data, 32'h100, "disabled_head");
        wr(2'd2, 32'h1);
        inj_ready = 1'b1;
        repeat (10) tick();
        rd_chk(2'd1, 32'h0005_0000, "drained_ovf_sticky");
        wr(2'd2, 32'h9);
        rd_chk(2'd1, 32'h0001_0000, "ovf_cleared");
        rd_chk(2'd2, 32'h0000_0001, "control_pulse_bits_read0");

        // Full FIFO: same-cycle pop does not admit the push
        inj_ready = 1'b0;
        wr(2'd2, 32'h0);
        for (int i = 0; i < 8; i++) push(32'h200 + i, 1'b1);
        rd_chk(2'd1, 32'h0002_0008, "refill_full");
        wr(2'd2, 32'h1);
        inj_ready = 1'b1;
        push(32'hDEAD_BEEF, 1'b0);
        inj_ready = 1'b0;
        rd_chk(2'd1, 32'h0004_0007, "full_pop_push_dropped");
        inj_ready = 1'b1;
        repeat (10) tick();
        wr(2'd2, 32'h9);
        rd_chk(2'd1, 32'h0001_0000, "after_full_drain");

        // Streaming with toggling ready: wrap, no loss or duplication
        for (int i = 0; i < 20; i++) begin
            inj_ready = (i % 4) != 3;
            push(32'h3000 + i, 1'b1);
        end
        inj_ready = 1'b1;
        repeat (10) tick();
        rd_chk(2'd1, 32'h0001_0000, "stream_drained");
        chk(exp_q.size(), 32'd0, "stream_queue_empty");

        // Empty interrupt and flush
        inj_ready = 1'b0;
        wr(2'd2, 32'h2);
        tick();
        chk({31'd0, irq}, 32'd1, "irq_empty");
        for (int i = 0; i < 3; i++) push(32'h4000 + i, 1'b0);
        tick();
        chk({31'd0, irq}, 32'd0, "irq_clears_nonempty");
        rd_chk(2'd0, 32'h4000, "peek_head");
        wr(2'd2, 32'h3);
        chk({31'd0, inj_valid}, 32'd1, "valid_before_flush");
        wr(2'd2, 32'h7);
        chk({31'd0, inj_valid}, 32'd0, "flush_valid_drop");
        chk(inj_data, 32'd0, "flush_inj_data");
        rd_chk(2'd1, 32'h0001_0000, "flush_status");
        rd_chk(2'd0, 32'h0, "flush_data_read");
        tick();
        tick();
        chk({31'd0, irq}, 32'd1, "flush_irq");
        rd_chk(2'd2, 32'h3, "flush_keeps_control");

        // Asynchronous reset mid-stream
        wr(2'd2, 32'h0);
        for (int i = 0; i < 2; i++) push(32'h5000 + i, 1'b0);
        reset_n = 1'b0;
        rd_chk(2'd1, 32'h0001_0000, "async_reset_status");
        rd_chk(2'd2, 32'h0, "async_reset_control");
        chk({31'd0, inj_valid}, 32'd0, "async_reset_valid");
        tick();
        reset_n = 1'b1;
        tick();
        chk(exp_q.size(), 32'd0, "final_queue_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
